// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control slice: forwarding selects, ResultSrc
// values and the data-cache miss FSM states.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StMiss = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand execute-stage forwarding select; the memory stage wins over writeback.
module fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_e_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic                      valid_m_i,
  input  logic                      reg_write_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      valid_w_i,
  input  logic                      reg_write_w_i,
  output fwd_sel_e                  sel_o
);

  logic hit_m;
  logic hit_w;

  always_comb begin
    hit_m = reg_write_m_i && valid_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i);
    hit_w = reg_write_w_i && valid_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i);
    sel_o = FWD_RF;
    if (hit_m) begin
      sel_o = FWD_M;
    end else if (hit_w) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline control master: stage enables/flushes, operand forwarding, dcache miss
// wait FSM and a saturating stall-cycle counter.
module hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter logic [1:0]  LOAD_SRC       = RES_LOAD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] RS1_d,
  input  logic [REG_ADDR_WIDTH-1:0] RS2_d,
  input  logic [REG_ADDR_WIDTH-1:0] RS1_e,
  input  logic [REG_ADDR_WIDTH-1:0] RS2_e,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_e,
  input  logic                      valid_e,
  input  logic                      RegWrite_e,
  input  logic [1:0]                ResultSrc_e,
  input  logic                      PCSrc_e,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_m,
  input  logic                      valid_m,
  input  logic                      RegWrite_m,
  input  logic [REG_ADDR_WIDTH-1:0] Rd_w,
  input  logic                      valid_w,
  input  logic                      RegWrite_w,
  input  logic                      dcache_miss_m,
  input  logic                      dcache_ready_m,
  output logic                      en_f,
  output logic                      en_d,
  output logic                      en_e,
  output logic                      en_m,
  output logic                      flush_d_n,
  output logic                      flush_e_n,
  output logic [1:0]                ForwardA_e,
  output logic [1:0]                ForwardB_e,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic                      busy
);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  fwd_sel_e              fwd_a, fwd_b;
  logic                  load_use;
  logic                  new_miss;
  logic                  frozen;
  logic                  stall_inc;

  fwd_sel #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_a (
    .rs_e_i       (RS1_e),
    .rd_m_i       (Rd_m),
    .valid_m_i    (valid_m),
    .reg_write_m_i(RegWrite_m),
    .rd_w_i       (Rd_w),
    .valid_w_i    (valid_w),
    .reg_write_w_i(RegWrite_w),
    .sel_o        (fwd_a)
  );

  fwd_sel #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_fwd_b (
    .rs_e_i       (RS2_e),
    .rd_m_i       (Rd_m),
    .valid_m_i    (valid_m),
    .reg_write_m_i(RegWrite_m),
    .rd_w_i       (Rd_w),
    .valid_w_i    (valid_w),
    .reg_write_w_i(RegWrite_w),
    .sel_o        (fwd_b)
  );

  always_comb begin
    load_use = valid_e && RegWrite_e && (ResultSrc_e == LOAD_SRC) && (Rd_e != '0) &&
               ((Rd_e == RS1_d) || (Rd_e == RS2_d));
    new_miss = (state_q == StRun) && dcache_miss_m && valid_m;
    // The refill-complete cycle behaves as RUN with no new miss.
    frozen   = ((state_q == StMiss) && !dcache_ready_m) || new_miss;

    state_d = state_q;
    unique case (state_q)
      StRun:   if (new_miss) state_d = StMiss;
      StMiss:  if (dcache_ready_m) state_d = StRun;
      default: state_d = StRun;
    endcase

    en_f      = 1'b1;
    en_d      = 1'b1;
    en_e      = 1'b1;
    en_m      = 1'b1;
    flush_d_n = 1'b1;
    flush_e_n = 1'b1;
    stall_inc = 1'b0;
    if (frozen) begin
      en_f      = 1'b0;
      en_d      = 1'b0;
      en_e      = 1'b0;
      en_m      = 1'b0;
      stall_inc = 1'b1;
    end else if (PCSrc_e) begin
      flush_d_n = 1'b0;
      flush_e_n = 1'b0;
    end else if (load_use) begin
      en_f      = 1'b0;
      en_d      = 1'b0;
      flush_e_n = 1'b0;
      stall_inc = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end

    ForwardA_e = fwd_a;
    ForwardB_e = fwd_b;
    busy       = (state_q == StMiss);

    if (rst) begin
      en_f       = 1'b0;
      en_d       = 1'b0;
      en_e       = 1'b0;
      en_m       = 1'b0;
      flush_d_n  = 1'b0;
      flush_e_n  = 1'b0;
      ForwardA_e = FWD_RF;
      ForwardB_e = FWD_RF;
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with hand-computed expectations.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RS1_d, RS2_d, RS1_e, RS2_e, Rd_e, Rd_m, Rd_w;
  logic        valid_e, RegWrite_e, PCSrc_e, valid_m, RegWrite_m, valid_w, RegWrite_w;
  logic [1:0]  ResultSrc_e;
  logic        dcache_miss_m, dcache_ready_m;
  logic        en_f, en_d, en_e, en_m, flush_d_n, flush_e_n, busy;
  logic [1:0]  ForwardA_e, ForwardB_e;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_unit dut (
    .clk           (clk),
    .rst           (rst),
    .RS1_d         (RS1_d),
    .RS2_d         (RS2_d),
    .RS1_e         (RS1_e),
    .RS2_e         (RS2_e),
    .Rd_e          (Rd_e),
    .valid_e       (valid_e),
    .RegWrite_e    (RegWrite_e),
    .ResultSrc_e   (ResultSrc_e),
    .PCSrc_e       (PCSrc_e),
    .Rd_m          (Rd_m),
    .valid_m       (valid_m),
    .RegWrite_m    (RegWrite_m),
    .Rd_w          (Rd_w),
    .valid_w       (valid_w),
    .RegWrite_w    (RegWrite_w),
    .dcache_miss_m (dcache_miss_m),
    .dcache_ready_m(dcache_ready_m),
    .en_f          (en_f),
    .en_d          (en_d),
    .en_e          (en_e),
    .en_m          (en_m),
    .flush_d_n     (flush_d_n),
    .flush_e_n     (flush_e_n),
    .ForwardA_e    (ForwardA_e),
    .ForwardB_e    (ForwardB_e),
    .stall_cnt     (stall_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control bundle packed as {en_f, en_d, en_e, en_m, flush_d_n, flush_e_n}.
  task automatic check_ctrl(input string tag, input logic [5:0] exp);
    check_eq(tag, {26'd0, en_f, en_d, en_e, en_m, flush_d_n, flush_e_n}, {26'd0, exp});
  endtask

  task automatic idle();
    RS1_d = 0; RS2_d = 0; RS1_e = 0; RS2_e = 0; Rd_e = 0; Rd_m = 0; Rd_w = 0;
    valid_e = 0; RegWrite_e = 0; ResultSrc_e = 2'b00; PCSrc_e = 0;
    valid_m = 0; RegWrite_m = 0; valid_w = 0; RegWrite_w = 0;
    dcache_miss_m = 0; dcache_ready_m = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    Rd_m = 5; RS1_e = 5; RegWrite_m = 1; valid_m = 1;
    #1;
    check_ctrl("rst_ctrl", 6'b000000);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_fwd_a", {30'd0, ForwardA_e}, 32'd0);
    cycle();
    check_eq("rst_cnt", stall_cnt, 32'd0);

    // Forwarding
    rst = 1'b0;
    idle();
    #1;
    check_ctrl("run_idle_ctrl", 6'b111111);
    Rd_m = 5; RS1_e = 5; RegWrite_m = 1; valid_m = 1;
    #1;
    check_eq("fwd_a_m", {30'd0, ForwardA_e}, 32'd2);
    check_eq("fwd_b_none", {30'd0, ForwardB_e}, 32'd0);
    Rd_m = 0; RS1_e = 0;
    #1;
    check_eq("fwd_a_x0", {30'd0, ForwardA_e}, 32'd0);
    Rd_m = 5; RS1_e = 5; Rd_w = 5; RegWrite_w = 1; valid_w = 1;
    #1;
    check_eq("fwd_a_m_prio", {30'd0, ForwardA_e}, 32'd2);
    valid_m = 0; RS2_e = 5;
    #1;
    check_eq("fwd_a_w", {30'd0, ForwardA_e}, 32'd1);
    check_eq("fwd_b_w", {30'd0, ForwardB_e}, 32'd1);
    cycle();

    // Load-use on rs2
    idle();
    valid_e = 1; RegWrite_e = 1; ResultSrc_e = 2'b01; Rd_e = 7; RS2_d = 7;
    #1;
    check_ctrl("lu_ctrl", 6'b001110);
    cycle();
    check_eq("lu_cnt", stall_cnt, 32'd1);
    idle();
    Rd_m = 7; RegWrite_m = 1; valid_m = 1; RS2_e = 7;
    #1;
    check_ctrl("lu_after_ctrl", 6'b111111);
    check_eq("lu_after_fwd_b", {30'd0, ForwardB_e}, 32'd2);
    cycle();
    check_eq("lu_after_cnt", stall_cnt, 32'd1);
    // Non-load and x0 destinations do not stall; rs1 match does
    idle();
    valid_e = 1; RegWrite_e = 1; ResultSrc_e = 2'b00; Rd_e = 3; RS1_d = 3;
    #1;
    check_ctrl("alu_no_stall", 6'b111111);
    ResultSrc_e = 2'b01; Rd_e = 0; RS1_d = 0;
    #1;
    check_ctrl("lu_x0_no_stall", 6'b111111);
    Rd_e = 3; RS1_d = 3;
    #1;
    check_ctrl("lu_rs1_ctrl", 6'b001110);
    cycle();
    check_eq("lu_rs1_cnt", stall_cnt, 32'd2);

    // Branch concurrent with load-use
    PCSrc_e = 1;
    #1;
    check_ctrl("br_lu_ctrl", 6'b111100);
    cycle();
    check_eq("br_lu_cnt", stall_cnt, 32'd2);

    // Ready while in RUN is ignored
    idle();
    dcache_ready_m = 1;
    #1;
    check_ctrl("ready_run_ctrl", 6'b111111);
    cycle();
    check_eq("ready_run_busy", {31'd0, busy}, 32'd0);

    // Miss, ready after 5 cycles
    idle();
    dcache_miss_m = 1; valid_m = 1;
    #1;
    check_ctrl("miss0_ctrl", 6'b000011);
    check_eq("miss0_busy", {31'd0, busy}, 32'd0);
    cycle();
    for (int i = 1; i < 5; i++) begin
      check_eq("miss_busy", {31'd0, busy}, 32'd1);
      check_ctrl("miss_ctrl", 6'b000011);
      cycle();
    end
    dcache_miss_m = 0; dcache_ready_m = 1;
    #1;
    check_eq("exit_busy", {31'd0, busy}, 32'd1);
    check_ctrl("exit_ctrl", 6'b111111);
    cycle();
    check_eq("miss_cnt", stall_cnt, 32'd7);
    check_eq("after_exit_busy", {31'd0, busy}, 32'd0);

    // Branch resolved while in MISS
    idle();
    dcache_miss_m = 1; valid_m = 1;
    cycle();
    PCSrc_e = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_ctrl("miss_br_ctrl", 6'b000011);
      cycle();
    end
    dcache_ready_m = 1;
    #1;
    check_ctrl("miss_br_exit", 6'b111100);
    cycle();
    check_eq("miss_br_cnt", stall_cnt, 32'd10);

    // Reset mid-MISS
    idle();
    dcache_miss_m = 1; valid_m = 1;
    cycle();
    cycle();
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    check_eq("pre_rst_cnt", stall_cnt, 32'd12);
    rst = 1'b1;
    #1;
    check_ctrl("mid_rst_ctrl", 6'b000000);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    cycle();
    check_eq("post_rst_cnt", stall_cnt, 32'd0);
    rst = 1'b0;
    idle();
    dcache_ready_m = 1;
    #1;
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
    check_ctrl("post_rst_ctrl", 6'b111111);
    cycle();
    idle();
    dcache_miss_m = 1; valid_m = 1;
    #1;
    check_ctrl("post_rst_miss", 6'b000011);
    cycle();
    check_eq("post_rst_miss_busy", {31'd0, busy}, 32'd1);
    check_eq("post_rst_miss_cnt", stall_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control master for the 5-stage pipelined core with data cache.
- Drives the stall enable (`en`, active-high) and flush (`rst_n`, active-low) inputs of the fetch, decode, execute and memory pipeline registers.
- Generates execute-stage operand forwarding selects.
- Holds a data-cache-miss wait FSM and a stall-cycle performance counter.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- CNT_WIDTH, 32, stall counter width.
- LOAD_SRC, 2'b01, ResultSrc encoding that marks a load.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- RS1_d, RS2_d  in  REG_ADDR_WIDTH  decode-stage source indices
- RS1_e, RS2_e, Rd_e  in  REG_ADDR_WIDTH  execute-stage indices
- valid_e, RegWrite_e  in  1  execute valid / write flag
- ResultSrc_e  in  2  execute result source
- PCSrc_e  in  1  taken branch/jump resolved in execute
- Rd_m  in  REG_ADDR_WIDTH; valid_m, RegWrite_m  in  1  memory stage
- Rd_w  in  REG_ADDR_WIDTH; valid_w, RegWrite_w  in  1  writeback stage
- dcache_miss_m  in  1  memory-stage access missed
- dcache_ready_m  in  1  refill complete, data valid
- en_f, en_d, en_e, en_m  out  1  stage enables (PC, fetch reg, decode reg, execute reg)
- flush_d_n, flush_e_n  out  1  active-low flush for fetch reg / decode reg
- ForwardA_e, ForwardB_e  out  2  00 regfile, 10 from M, 01 from W
- stall_cnt  out  CNT_WIDTH  total stall cycles
- busy  out  1  FSM in MISS

Behaviour:
- **Reset** (rst=1 at clk edge): state=RUN, stall_cnt=0.
  - While rst is high, outputs are combinationally forced: all en_*=0, flush_d_n=0, flush_e_n=0, ForwardA_e/ForwardB_e=00, busy=0.
- **FSM states: RUN, MISS.**
  - RUN→MISS when dcache_miss_m=1 and valid_m=1.
  - MISS→RUN on the cycle dcache_ready_m=1.
  - dcache_ready_m in RUN is ignored.
- **Forwarding** (combinational, every cycle):
  - ForwardA_e=10 if RegWrite_m & valid_m & Rd_m!=0 & Rd_m==RS1_e.
  - Else 01 if the same test holds with the W signals.
  - Else 00.
  - M has priority over W. Same rules for ForwardB_e with RS2_e.
- **Load-use** (lu) = valid_e & RegWrite_e & ResultSrc_e==LOAD_SRC & Rd_e!=0 & (Rd_e==RS1_d | Rd_e==RS2_d).
  - Comparison is done regardless of whether the instruction actually uses rs2.
- **Control priority** (combinational from state and inputs):
  1. MISS, or RUN with a new miss this cycle: all en_*=0; flush_d_n=flush_e_n=1. Pipeline frozen, PCSrc_e held and honoured after exit.
  2. PCSrc_e=1: all en=1; flush_d_n=0, flush_e_n=0 (kill the 2 younger instructions). lu is ignored because the load-use consumer is flushed.
  3. lu=1: en_f=en_d=0; en_e=en_m=1; flush_e_n=0 (one bubble into execute); flush_d_n=1. Exactly one bubble per load-use pair, since the next cycle the load is in M and is forwarded.
  4. Otherwise all en=1, flushes=1.
- **MISS exit cycle** (dcache_ready_m=1 in MISS): control is evaluated as RUN with no new miss, so an execute-stage branch or lu takes effect in that same cycle.
- **stall_cnt:** +1 on each cycle in cases 1 or 3. Saturates at all-ones with no wrap. Cleared only by rst.
- **busy:** busy=1 iff state==MISS.
- **Reset mid-MISS:** returns to RUN next edge; a pending refill is discarded.
- No other latency; only state and stall_cnt are registered.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - forward select enum (FWD_RF=00, FWD_W=01, FWD_M=10);
  - ResultSrc encodings (incl. LOAD_SRC);
  - FSM state enum.
- One natural sub-module: fwd_sel, the combinational per-operand forwarding mux select. It is instantiated twice, for A and B.

Test Plan:
1. `addi x5` in M, RS1_e=5, RegWrite_m=1, valid_m=1 -> ForwardA_e=10; same with Rd_m=0 -> 00; both M and W write x5 -> 10.
2. `lw x7` in E (ResultSrc_e=01), RS2_d=7 -> en_f=en_d=0, flush_e_n=0 for exactly 1 cycle; stall_cnt 0→1.
3. PCSrc_e=1 concurrent with load-use -> flush_d_n=flush_e_n=0, all en=1, stall_cnt unchanged.
4. dcache_miss_m=1 valid_m=1, ready after 5 cycles -> busy=1 and all en=0 for 5 cycles; RUN on the ready cycle; stall_cnt=5.
5. Branch resolved while in MISS -> no flush until the exit cycle, then flush_d_n=flush_e_n=0 on that cycle.
6. rst asserted mid-MISS -> next cycle busy=0, stall_cnt=0; while rst is high all en=0 and flushes=0; normal RUN after release.
